// File: rtl/window_match_fsm_pkg.sv
// Shared types and the window comparison used by the window-match detector.
package window_fsm_pkg;

    typedef enum logic [1:0] {
        MATCH_EXACT,
        MATCH_AT_LEAST,
        MATCH_AT_MOST
    } match_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } win_state_e;

    function automatic logic cmp(input int unsigned count, input int unsigned target,
                                 input match_mode_e mode);
        case (mode)
            MATCH_EXACT:    return count == target;
            MATCH_AT_LEAST: return count >= target;
            MATCH_AT_MOST:  return count <= target;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/window_match_fsm_if.sv
// Arm/data/stop inputs and registered status outputs of the window-match detector.
interface window_match_fsm_if #(
    parameter int HIT_W = 8
);
    logic             s;
    logic             w;
    logic             stop;
    logic             z;
    logic             win_done;
    logic             busy;
    logic [HIT_W-1:0] hit_count;

    modport master (output s, w, stop, input z, win_done, busy, hit_count);
    modport slave  (input s, w, stop, output z, win_done, busy, hit_count);
endinterface

// File: rtl/window_match_fsm_tally.sv
// Position and ones counters for one sampling window; wraps to zero after the last sample.
module window_tally #(
    parameter int WIN_LEN = 3,
    parameter int CW      = $clog2(WIN_LEN + 1)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          sample_en,
    input  logic          w,
    output logic          last,
    output logic [CW-1:0] ones_total
);
    logic [CW-1:0] pos;
    logic [CW-1:0] ones;

    assign last       = (pos == CW'(WIN_LEN - 1));
    // Includes the current sample, so it is the full window count on the last cycle.
    assign ones_total = ones + CW'(w);

    always_ff @(posedge clk) begin
        if (clear) begin
            pos  <= '0;
            ones <= '0;
        end else if (sample_en) begin
            if (last) begin
                pos  <= '0;
                ones <= '0;
            end else begin
                pos  <= pos + CW'(1);
                ones <= ones_total;
            end
        end
    end
endmodule

// File: rtl/window_match_fsm.sv
// Armed window detector: counts w ones over back-to-back WIN_LEN windows and flags matches.
module window_match_fsm
    import window_fsm_pkg::*;
#(
    parameter int          WIN_LEN = 3,
    parameter int          TARGET  = 2,
    parameter match_mode_e MODE    = MATCH_EXACT,
    parameter int          HIT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    window_match_fsm_if.slave bus
);
    localparam int               CW      = $clog2(WIN_LEN + 1);
    localparam logic [0:0]       ST_IDLE = IDLE;
    localparam logic [0:0]       ST_RUN  = RUN;
    localparam logic [CW-1:0]    TGT     = CW'(TARGET);
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    generate
        if (WIN_LEN < 1 || TARGET > WIN_LEN) begin : g_bad_params
            $fatal(1, "window_match_fsm: need WIN_LEN >= 1 and TARGET <= WIN_LEN");
        end
    endgenerate

    logic [0:0]       state;
    logic             run;
    logic             last;
    logic             fire;
    logic             hit_now;
    logic [CW-1:0]    ones_total;
    logic             z_q;
    logic             done_q;
    logic [HIT_W-1:0] hit_q;

    assign run     = (state == ST_RUN);
    // stop discards the window even on its last sample.
    assign fire    = run & ~bus.stop & last;
    assign hit_now = fire & cmp(32'(ones_total), 32'(TGT), MODE);

    window_tally #(.WIN_LEN(WIN_LEN), .CW(CW)) u_tally (
        .clk        (clk),
        .clear      (reset | ~run),
        .sample_en  (run & ~bus.stop),
        .w          (bus.w),
        .last       (last),
        .ones_total (ones_total)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            z_q    <= 1'b0;
            done_q <= 1'b0;
            hit_q  <= '0;
        end else begin
            z_q    <= hit_now;
            done_q <= fire;
            if (hit_now && hit_q != HIT_MAX)
                hit_q <= hit_q + HIT_W'(1);
            case (state)
                ST_IDLE: if (bus.s && !bus.stop) state <= ST_RUN;
                default: if (bus.stop)           state <= ST_IDLE;
            endcase
        end
    end

    assign bus.z         = z_q;
    assign bus.win_done  = done_q;
    assign bus.busy      = run;
    assign bus.hit_count = hit_q;
endmodule

// File: tb/tb_window_match_fsm.sv
// Scoreboard bench for window_match_fsm across four parameter sets driven in lockstep.
module tb_window_match_fsm;
    import window_fsm_pkg::*;

    logic clk = 1'b0, reset = 1'b0, s = 1'b0, w = 1'b0, stop = 1'b0;
    always #5 clk = ~clk;

    // d0 default, d1 at-least, d2 HIT_W=2, d3 WIN_LEN=1/TARGET=1
    window_match_fsm_if #(.HIT_W(8)) b0 ();
    window_match_fsm_if #(.HIT_W(8)) b1 ();
    window_match_fsm_if #(.HIT_W(2)) b2 ();
    window_match_fsm_if #(.HIT_W(8)) b3 ();

    assign b0.s = s;  assign b0.w = w;  assign b0.stop = stop;
    assign b1.s = s;  assign b1.w = w;  assign b1.stop = stop;
    assign b2.s = s;  assign b2.w = w;  assign b2.stop = stop;
    assign b3.s = s;  assign b3.w = w;  assign b3.stop = stop;

    window_match_fsm d0 (.clk(clk), .reset(reset), .bus(b0.slave));
    window_match_fsm #(.MODE(MATCH_AT_LEAST)) d1 (.clk(clk), .reset(reset), .bus(b1.slave));
    window_match_fsm #(.HIT_W(2)) d2 (.clk(clk), .reset(reset), .bus(b2.slave));
    window_match_fsm #(.WIN_LEN(1), .TARGET(1)) d3 (.clk(clk), .reset(reset), .bus(b3.slave));

    typedef struct packed {
        logic [3:0]      z;
        logic [3:0]      wd;
        logic            busy;
        logic [3:0][7:0] h;
    } exp_t;

    exp_t sbq[$];
    exp_t me, ma;
    int   vectors = 0, errs = 0, cyc = 0;

    int wl[4] = '{3, 3, 3, 1};
    int tg[4] = '{2, 2, 2, 1};
    int md[4] = '{0, 1, 0, 0};
    int hm[4] = '{255, 255, 3, 255};
    int pos_m[4], ones_m[4], hit_m[4];
    bit m_run = 1'b0;

    function automatic bit exp_match(input int c, input int t, input int m);
        if (m == 1) return c >= t;
        if (m == 2) return c <= t;
        return c == t;
    endfunction

    // Drive one cycle of inputs, push the reference outputs expected after the edge.
    task automatic tick(input logic r, input logic sv, input logic wv, input logic st);
        exp_t e;
        int   t;
        reset = r; s = sv; w = wv; stop = st;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                pos_m[k] = 0; ones_m[k] = 0; hit_m[k] = 0;
            end else if (m_run && !st) begin
                t = ones_m[k] + int'(wv);
                if (pos_m[k] == wl[k] - 1) begin
                    e.wd[k] = 1'b1;
                    e.z[k]  = exp_match(t, tg[k], md[k]);
                    pos_m[k] = 0; ones_m[k] = 0;
                    if (e.z[k] && hit_m[k] < hm[k]) hit_m[k]++;
                end else begin
                    pos_m[k]++; ones_m[k] = t;
                end
            end else begin
                pos_m[k] = 0; ones_m[k] = 0;
            end
            e.h[k] = 8'(hit_m[k]);
        end
        if (r)           m_run = 1'b0;
        else if (!m_run) m_run = sv && !st;
        else             m_run = !st;
        e.busy = m_run;
        sbq.push_back(e);
        @(posedge clk);
        #2;
        cyc++;
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            ma.z    = {b3.z, b2.z, b1.z, b0.z};
            ma.wd   = {b3.win_done, b2.win_done, b1.win_done, b0.win_done};
            ma.busy = b0.busy;
            ma.h    = {b3.hit_count, {6'b0, b2.hit_count}, b1.hit_count, b0.hit_count};
            vectors++;
            if (ma !== me || b1.busy !== b0.busy || b2.busy !== b0.busy || b3.busy !== b0.busy) begin
                errs++;
                $display("FAIL sb cyc=%0d got z=%b wd=%b busy=%b%b%b%b hit=%h want z=%b wd=%b busy=%b hit=%h",
                         cyc, ma.z, ma.wd, b3.busy, b2.busy, b1.busy, b0.busy, ma.h,
                         me.z, me.wd, me.busy, me.h);
            end
        end
    end

    task automatic test_reset();
        tick(1, 1, 1, 0);
        tick(1, 0, 0, 0);
        vectors++;
        if (b0.z !== 1'b0 || b0.win_done !== 1'b0 || b0.busy !== 1'b0 || b0.hit_count !== 8'd0) begin
            errs++;
            $display("FAIL reset: z=%b wd=%b busy=%b hit=%0d want 0 0 0 0",
                     b0.z, b0.win_done, b0.busy, b0.hit_count);
        end
    endtask

    task automatic test_exact();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        vectors++;
        if (b0.busy !== 1'b1 || b0.win_done !== 1'b0 || b3.win_done !== 1'b0) begin
            errs++;
            $display("FAIL exact_arm: busy=%b wd=%b wd3=%b want 1 0 0", b0.busy, b0.win_done, b3.win_done);
        end
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        vectors++;
        if (b0.z !== 1'b1 || b0.win_done !== 1'b1 || b0.hit_count !== 8'd1) begin
            errs++;
            $display("FAIL exact_win: z=%b wd=%b hit=%0d want 1 1 1", b0.z, b0.win_done, b0.hit_count);
        end
        vectors++;
        if (b3.z !== 1'b0 || b3.win_done !== 1'b1 || b3.hit_count !== 8'd2) begin
            errs++;
            $display("FAIL win1: z=%b wd=%b hit=%0d want 0 1 2", b3.z, b3.win_done, b3.hit_count);
        end
        tick(0, 0, 1, 1);
        vectors++;
        if (b0.z !== 1'b0 || b0.win_done !== 1'b0 || b0.busy !== 1'b0) begin
            errs++;
            $display("FAIL exact_once: z=%b wd=%b busy=%b want 0 0 0", b0.z, b0.win_done, b0.busy);
        end
    endtask

    task automatic test_mode();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        vectors++;
        if (b0.z !== 1'b0 || b0.win_done !== 1'b1 || b1.z !== 1'b1 || b1.win_done !== 1'b1) begin
            errs++;
            $display("FAIL mode: exact z=%b wd=%b atleast z=%b wd=%b want 0 1 1 1",
                     b0.z, b0.win_done, b1.z, b1.win_done);
        end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat = 6'b100_101;
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, pat[i], 0);
            if (i == 2) begin
                vectors++;
                if (b0.z !== 1'b1 || b0.win_done !== 1'b1) begin
                    errs++;
                    $display("FAIL b2b_w1: z=%b wd=%b want 1 1", b0.z, b0.win_done);
                end
            end
        end
        vectors++;
        if (b0.z !== 1'b0 || b0.win_done !== 1'b1 || b0.hit_count !== 8'd1 || b0.busy !== 1'b1) begin
            errs++;
            $display("FAIL b2b_w2: z=%b wd=%b hit=%0d busy=%b want 0 1 1 1",
                     b0.z, b0.win_done, b0.hit_count, b0.busy);
        end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_stop();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 1);
        vectors++;
        if (b0.busy !== 1'b0 || b0.z !== 1'b0 || b0.win_done !== 1'b0 || b1.win_done !== 1'b0) begin
            errs++;
            $display("FAIL stop: busy=%b z=%b wd=%b wd1=%b want 0 0 0 0",
                     b0.busy, b0.z, b0.win_done, b1.win_done);
        end
        for (int i = 0; i < 5; i++) tick(0, 0, 1'($urandom_range(0, 1)), 0);
        vectors++;
        if (b0.busy !== 1'b0 || b0.hit_count !== 8'd0) begin
            errs++;
            $display("FAIL stop_idle: busy=%b hit=%0d want 0 0", b0.busy, b0.hit_count);
        end
    endtask

    task automatic test_saturate();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 1, 0);
            tick(0, 0, 1, 0);
            tick(0, 0, 0, 0);
            vectors++;
            if (b2.hit_count !== 2'((i + 1 > 3) ? 3 : i + 1) || b0.hit_count !== 8'(i + 1)) begin
                errs++;
                $display("FAIL sat_%0d: hit2=%0d hit0=%0d want %0d %0d",
                         i, b2.hit_count, b0.hit_count, (i + 1 > 3) ? 3 : i + 1, i + 1);
            end
        end
        tick(0, 0, 0, 1);
        vectors++;
        if (b2.hit_count !== 2'd3 || b0.hit_count !== 8'd6) begin
            errs++;
            $display("FAIL sat_stop: hit2=%0d hit0=%0d want 3 6", b2.hit_count, b0.hit_count);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 1, 0);
        vectors++;
        if (b0.z !== 1'b0 || b0.win_done !== 1'b0 || b0.busy !== 1'b0 || b0.hit_count !== 8'd0) begin
            errs++;
            $display("FAIL rst_mid: z=%b wd=%b busy=%b hit=%0d want 0 0 0 0",
                     b0.z, b0.win_done, b0.busy, b0.hit_count);
        end
        tick(0, 1, 1, 1);
        tick(0, 0, 1, 0);
        vectors++;
        if (b0.busy !== 1'b0 || b3.busy !== 1'b0) begin
            errs++;
            $display("FAIL s_and_stop: busy=%b busy3=%b want 0 0", b0.busy, b3.busy);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_mode();
        test_back_to_back();
        test_stop();
        test_saturate();
        test_reset_mid();
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
